pe_mac_driver: RTL and testbench
================================

// Module: pe_mac_driver
// PURPOSE
//  Drives one int8 PE (pe_int8_lut / pe_int8_dsp) through a full dot-product.
//  Accepts K operand pairs on a valid/ready stream and issues pe_a/pe_b/pe_clr/pe_en.
//  Waits out PE latency, then captures pe_acc and returns it on a valid/ready result port.
//  Sits between the tile operand scheduler and each PE column head.
// PARAMETERS
//  ELEM_BITS  8   operand width, signed two's complement
//  ACC_BITS   32  PE accumulator / result width
//  LEN_BITS   16  width of dot-product length K
//  PE_LAT     1   cycles from PE's enable edge until pe_acc reflects that beat (>=1)
// PORTS
//  clk        in   1          clock; all logic on posedge
//  rst        in   1          synchronous reset, active-high
//  start      in   1          begin job; sampled only in IDLE
//  len        in   LEN_BITS   K, sampled with start
//  busy       out  1          high in every state except IDLE
//  op_valid   in   1          operand pair valid
//  op_ready   out  1          high only in RUN
//  op_a       in   ELEM_BITS  signed operand A
//  op_b       in   ELEM_BITS  signed operand B
//  pe_a       out  ELEM_BITS  registered operand A to PE
//  pe_b       out  ELEM_BITS  registered operand B to PE
//  pe_en      out  1          registered PE accumulate enable
//  pe_clr     out  1          registered PE clear; coincides with first pe_en of a job
//  pe_acc     in   ACC_BITS   PE accumulator output
//  res_valid  out  1          result valid; held until accepted
//  res_ready  in   1          result consumer ready
//  res_data   out  ACC_BITS   captured dot-product, signed
//  perf_stall out  16         stall counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; pe_a/pe_b/res_data=0; pe_en/pe_clr/res_valid/busy/op_ready=0; counters=0.
//  PE contract: at PE edge with en=1, acc <= clr ? a*b : acc + a*b; en=0 holds acc.
//  FSM: IDLE -> RUN on start && len!=0; IDLE -> DONE on start && len==0 (res_data=0, no pe_en).
//   RUN: each beat (op_valid && op_ready) registers op_a/op_b into pe_a/pe_b, pe_en=1 next cycle.
//    pe_clr=1 only on the job's first beat. No beat in a cycle -> pe_en=0, pe_clr=0 next cycle.
//    Beat counter increments per beat; beat K (count==len-1) -> DRAIN; op_ready drops same edge.
//   DRAIN: counter d cleared on entry, +1 per cycle; when d==PE_LAT, res_data<=pe_acc, -> DONE.
//    Last beat accepted at edge N => res_data captured at edge N+1+PE_LAT; res_valid high after it.
//   DONE: res_valid=1, res_data stable; res_valid && res_ready -> IDLE. res_valid then 0.
//  Zero-bubble: start may be asserted in the cycle after acceptance; job-to-job gap = 1 IDLE cycle.
//  start while busy: ignored, no side effects. len sampled once; later changes ignored.
//  op_valid gaps in RUN: stall only; PE sees en=0 and holds accumulator.
//  res_data is pe_acc verbatim (no extra sign/width conversion); wrap is the PE's modulo 2^ACC_BITS.
//  rst in any state: synchronous return to reset values; partial job discarded, PE not cleared.
// CONFIGURATION
//  PE_DRV_PERF_EN defined: perf_stall counts RUN cycles with op_valid=0.
//   Counter is cleared on each IDLE->RUN and saturates at 16'hFFFF; it is valid while in DONE.
//  PE_DRV_PERF_EN undefined: perf_stall tied to 0; no counter logic.
// TESTING
//  T1 len=6, A={127,-128,127,-5,-1,0}, B={127,-128,-128,7,127,0}, op_valid=1 -> res_data=16095.
//  T2 T1 data, op_valid low 3 cycles between beats 2 and 3 -> res_data=16095, perf_stall=3 (PERF_EN).
//  T3 len=0 start -> DONE next cycle, res_data=0, pe_en never asserted.
//  T4 len=2 {(-128,-128),(-128,-128)} -> res_data=32768; res_ready low 5 cycles -> valid/data held.
//  T5 back-to-back jobs len=1 (3,4) then (-2,5) -> 12 then -10; pe_clr once per job.
//  T6 rst in RUN after 2 of 4 beats -> all outputs at reset values; next len=1 (7,7) -> 49.
//  All: check res_data timing N+1+PE_LAT for PE_LAT=1 and PE_LAT=3, with both PE variants.

Source files
------------

// File: rtl/pe_mac_driver.sv
// Sequences one int8 PE through a K-beat dot product and returns its accumulator on a valid/ready port.
// Optional stall counter on perf_stall is enabled by defining PE_DRV_PERF_EN.
module pe_mac_driver #(
  parameter int ELEM_BITS = 8,
  parameter int ACC_BITS  = 32,
  parameter int LEN_BITS  = 16,
  parameter int PE_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_BITS-1:0]  len,
  output logic                 busy,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [ELEM_BITS-1:0] op_a,
  input  logic [ELEM_BITS-1:0] op_b,
  output logic [ELEM_BITS-1:0] pe_a,
  output logic [ELEM_BITS-1:0] pe_b,
  output logic                 pe_en,
  output logic                 pe_clr,
  input  logic [ACC_BITS-1:0]  pe_acc,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_BITS-1:0]  res_data,
  output logic [15:0]          perf_stall
);

  localparam int DW = $clog2(PE_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state, state_next;
  logic [LEN_BITS-1:0] len_q;
  logic [LEN_BITS-1:0] beat_cnt;
  logic [DW-1:0]       drain_cnt;
  logic                beat;
  logic                last_beat;
  logic                drain_done;

  assign beat       = op_valid && (state == RUN);
  assign last_beat  = beat && (beat_cnt == len_q - LEN_BITS'(1));
  assign drain_done = (state == DRAIN) && (drain_cnt == DW'(PE_LAT));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    op_ready   = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        op_ready = 1'b1;
        if (last_beat) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // pe_en/pe_clr follow each accepted beat by one cycle; clr marks the job's first beat
  always_ff @(posedge clk) begin
    if (rst) begin
      pe_a      <= '0;
      pe_b      <= '0;
      pe_en     <= 1'b0;
      pe_clr    <= 1'b0;
      res_data  <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      pe_en  <= beat;
      pe_clr <= beat && (beat_cnt == '0);
      if (beat) begin
        pe_a <= op_a;
        pe_b <= op_b;
      end
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            beat_cnt <= '0;
            if (len == '0) res_data <= '0;
          end
        end
        RUN: begin
          drain_cnt <= '0;
          if (beat) beat_cnt <= beat_cnt + LEN_BITS'(1);
        end
        DRAIN: begin
          if (drain_done) res_data  <= pe_acc;
          else            drain_cnt <= drain_cnt + DW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PE_DRV_PERF_EN
  logic [15:0] stall_cnt;

  // Saturating count of RUN cycles with no operand offered
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start && len != '0) begin
      stall_cnt <= '0;
    end else if (state == RUN && !op_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign perf_stall = stall_cnt;
`else
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_pe_mac_driver.sv
// Directed bench for pe_mac_driver with a behavioural PE whose latency follows PE_LAT.
// Define PE_DRV_PERF_EN to also check the stall counter.
module tb_pe_mac_driver;
  parameter int PE_LAT = 1;
  localparam int EB = 8;
  localparam int AB = 32;
  localparam int LB = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [LB-1:0] len;
  logic          busy;
  logic          op_valid;
  logic          op_ready;
  logic [EB-1:0] op_a, op_b;
  logic [EB-1:0] pe_a, pe_b;
  logic          pe_en, pe_clr;
  logic [AB-1:0] pe_acc;
  logic          res_valid;
  logic          res_ready;
  logic [AB-1:0] res_data;
  logic [15:0]   perf_stall;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0;
  int clr_cnt = 0;

  pe_mac_driver #(.ELEM_BITS(EB), .ACC_BITS(AB), .LEN_BITS(LB), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .pe_a(pe_a), .pe_b(pe_b), .pe_en(pe_en), .pe_clr(pe_clr), .pe_acc(pe_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .perf_stall(perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PE: accumulate on en, then PE_LAT-1 extra output stages
  logic signed [AB-1:0] prod;
  logic signed [AB-1:0] acc_pipe [PE_LAT];
  assign prod   = $signed({{(AB-EB){pe_a[EB-1]}}, pe_a}) * $signed({{(AB-EB){pe_b[EB-1]}}, pe_b});
  assign pe_acc = acc_pipe[PE_LAT-1];

  initial for (int i = 0; i < PE_LAT; i++) acc_pipe[i] = '0;

  always @(posedge clk) begin
    if (pe_en) acc_pipe[0] <= pe_clr ? prod : acc_pipe[0] + prod;
    for (int i = 1; i < PE_LAT; i++) acc_pipe[i] <= acc_pipe[i-1];
    cyc <= cyc + 1;
    if (pe_en)  en_cnt  <= en_cnt + 1;
    if (pe_clr) clr_cnt <= clr_cnt + 1;
  end

  typedef struct {
    int             len;
    logic [7:0][EB-1:0] a;
    logic [7:0][EB-1:0] b;
    int             gap_at;
    int             gap_len;
    int             hold;
    int             exp_res;
    int             exp_stall;
  } job_vec_t;

  job_vec_t vecs [6];

  function automatic void add_job(int idx, int l, int gat, int glen, int hold, int res, int stall);
    vecs[idx].len       = l;
    vecs[idx].a         = '0;
    vecs[idx].b         = '0;
    vecs[idx].gap_at    = gat;
    vecs[idx].gap_len   = glen;
    vecs[idx].hold      = hold;
    vecs[idx].exp_res   = res;
    vecs[idx].exp_stall = stall;
  endfunction

  function automatic void set_pair(int idx, int k, int a, int b);
    vecs[idx].a[k] = EB'(a);
    vecs[idx].b[k] = EB'(b);
  endfunction

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Runs one table job; called at a negedge, returns at the negedge after result acceptance
  task automatic applyStimulus(input int idx);
    job_vec_t job;
    int k, gaps, guard, last_edge, en0, clr0;
    job   = vecs[idx];
    en0   = en_cnt;
    clr0  = clr_cnt;
    start = 1'b1;
    len   = LB'(job.len);
    @(negedge clk);
    len = 16'hBEEF;
    checkOutput($sformatf("job%0d_busy", idx), busy, 1);
    k = 0; gaps = 0; guard = 0; last_edge = 0;
    while (k < job.len && guard < 100) begin
      if (k == job.gap_at && gaps < job.gap_len) begin
        op_valid = 1'b0;
        op_a     = 8'h55;
        op_b     = 8'h55;
        gaps++;
      end else begin
        op_valid = 1'b1;
        op_a     = job.a[k];
        op_b     = job.b[k];
      end
      if (op_valid && op_ready) begin
        k++;
        last_edge = cyc + 1;
      end
      @(negedge clk);
      guard++;
    end
    op_valid = 1'b0;
    start    = 1'b0;
    checkOutput($sformatf("job%0d_beats", idx), k, job.len);
    checkOutput($sformatf("job%0d_op_ready_drop", idx), op_ready, 0);
    guard = 0;
    while (!res_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput($sformatf("job%0d_res_valid", idx), res_valid, 1);
    checkOutput($sformatf("job%0d_latency", idx), cyc, last_edge + 1 + PE_LAT);
    checkOutput($sformatf("job%0d_res_data", idx), $signed(res_data), job.exp_res);
    checkOutput($sformatf("job%0d_en_count", idx), en_cnt - en0, job.len);
    checkOutput($sformatf("job%0d_clr_count", idx), clr_cnt - clr0, 1);
`ifdef PE_DRV_PERF_EN
    checkOutput($sformatf("job%0d_perf_stall", idx), perf_stall, job.exp_stall);
`endif
    res_ready = 1'b0;
    for (int h = 0; h < job.hold; h++) begin
      @(negedge clk);
      checkOutput($sformatf("job%0d_hold_valid", idx), res_valid, 1);
      checkOutput($sformatf("job%0d_hold_data", idx), $signed(res_data), job.exp_res);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput($sformatf("job%0d_valid_drop", idx), res_valid, 0);
    checkOutput($sformatf("job%0d_idle", idx), busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t1a[6] = '{127, -128, 127, -5, -1, 0};
    int t1b[6] = '{127, -128, -128, 7, 127, 0};
    int en0;

    add_job(0, 6, -1, 0, 0, 16095, 0);
    add_job(1, 6, 2, 3, 0, 16095, 3);
    for (int i = 0; i < 6; i++) begin
      set_pair(0, i, t1a[i], t1b[i]);
      set_pair(1, i, t1a[i], t1b[i]);
    end
    add_job(2, 2, -1, 0, 5, 32768, 0);
    set_pair(2, 0, -128, -128);
    set_pair(2, 1, -128, -128);
    add_job(3, 1, -1, 0, 0, 12, 0);
    set_pair(3, 0, 3, 4);
    add_job(4, 1, -1, 0, 0, -10, 0);
    set_pair(4, 0, -2, 5);
    add_job(5, 1, -1, 0, 0, 49, 0);
    set_pair(5, 0, 7, 7);

    rst = 1'b1; start = 1'b0; len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_op_ready", op_ready, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_pe_en", pe_en, 0);
    checkOutput("rst_pe_clr", pe_clr, 0);
    checkOutput("rst_res_data", $signed(res_data), 0);
    checkOutput("rst_perf_stall", perf_stall, 0);
    rst = 1'b0;

    for (int j = 0; j < 2; j++) applyStimulus(j);

    // Zero-length job goes straight to DONE with a cleared result
    en0   = en_cnt;
    start = 1'b1;
    len   = '0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("len0_res_valid", res_valid, 1);
    checkOutput("len0_res_data", $signed(res_data), 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("len0_valid_drop", res_valid, 0);
    checkOutput("len0_no_pe_en", en_cnt - en0, 0);

    for (int j = 2; j < 5; j++) applyStimulus(j);

    // Reset mid-job after two of four beats
    start = 1'b1;
    len   = 16'd4;
    @(negedge clk);
    start = 1'b0;
    op_valid = 1'b1; op_a = 8'd10; op_b = 8'd10;
    @(negedge clk);
    op_a = 8'd20; op_b = 8'd20;
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_op_ready", op_ready, 0);
    checkOutput("midrst_pe_en", pe_en, 0);
    checkOutput("midrst_pe_clr", pe_clr, 0);
    checkOutput("midrst_pe_a", pe_a, 0);
    checkOutput("midrst_pe_b", pe_b, 0);
    checkOutput("midrst_res_valid", res_valid, 0);
    checkOutput("midrst_res_data", $signed(res_data), 0);
    checkOutput("midrst_perf_stall", perf_stall, 0);

    applyStimulus(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
